// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank sequencer: widths, instruction
// field positions, the FSM state encoding and small decode helpers.
package reg_bank_pkg;

   localparam int DATA_W  = 8;
   localparam int REG_CNT = 8;
   localparam int ADDR_W  = $clog2(REG_CNT);
   localparam int INSTR_W = 16;
   localparam int OP_W    = 3;
   localparam int FLAG_W  = 3;

   // Instruction field bit positions
   localparam int LDI_BIT     = 15;
   localparam int OP_MSB      = 14;
   localparam int OP_LSB      = 12;
   localparam int LDI_DST_MSB = 14;
   localparam int LDI_DST_LSB = 12;
   localparam int IMM_MSB     = 7;
   localparam int IMM_LSB     = 0;
   localparam int DST_MSB     = 11;
   localparam int DST_LSB     = 9;
   localparam int SRCX_MSB    = 8;
   localparam int SRCX_LSB    = 6;
   localparam int SRCY_MSB    = 5;
   localparam int SRCY_LSB    = 3;

   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [OP_W-1:0]    op_t;
   typedef logic [FLAG_W-1:0]  flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      EX   = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_ldi(instr_t instr);
      return instr[LDI_BIT];
   endfunction

   // Destination field lives in a different place for LDI and ALU formats
   function automatic addr_t dst_of(instr_t instr);
      return instr[LDI_BIT] ? instr[LDI_DST_MSB:LDI_DST_LSB] : instr[DST_MSB:DST_LSB];
   endfunction

endpackage

// File: rtl/reg_bank_seq_if.sv
// Instruction handshake, ALU operand/result, flag, retire and debug-read
// signals of the sequencer. The sequencer is the slave; whoever issues
// instructions and models the ALU is the master.
interface reg_bank_seq_if;
   import reg_bank_pkg::*;

   instr_t instr_i;
   logic   instr_valid_i;
   logic   instr_ready_o;
   data_t  alu_rx_o;
   data_t  alu_ry_o;
   op_t    alu_sel_op_o;
   data_t  alu_r0_i;
   flags_t alu_ban_i;
   flags_t flags_o;
   logic   done_o;
   addr_t  rd_addr_i;
   data_t  rd_data_o;

   modport slave (
      input  instr_i, instr_valid_i, alu_r0_i, alu_ban_i, rd_addr_i,
      output instr_ready_o, alu_rx_o, alu_ry_o, alu_sel_op_o, flags_o, done_o, rd_data_o
   );

   modport master (
      output instr_i, instr_valid_i, alu_r0_i, alu_ban_i, rd_addr_i,
      input  instr_ready_o, alu_rx_o, alu_ry_o, alu_sel_op_o, flags_o, done_o, rd_data_o
   );

endinterface

// File: rtl/reg_bank_rf.sv
// Register file: one synchronous write port, two combinational operand read
// ports and a registered debug read port. All entries clear on reset.
module reg_bank_rf #(
   parameter int DATA_W  = reg_bank_pkg::DATA_W,
   parameter int REG_CNT = reg_bank_pkg::REG_CNT,
   localparam int ADDR_W = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_x,
   output logic [DATA_W-1:0] rdata_x,
   input  logic [ADDR_W-1:0] raddr_y,
   output logic [DATA_W-1:0] rdata_y,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] bank [REG_CNT];

   // Bank storage: clear on reset, single write port
   // NOTE: every entry is reset because software relies on registers reading
   // zero after reset; this keeps the array in flops rather than a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) begin
            bank[i] <= '0;
         end
      end else if (we) begin
         // NOTE: non-blocking so every reader this edge sees the pre-write value.
         bank[waddr] <= wdata;
      end
   end

   assign rdata_x = bank[raddr_x];
   assign rdata_y = bank[raddr_y];

   // Debug read: registered, so a same-edge write shows up one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_data <= '0;
      end else begin
         dbg_data <= bank[dbg_addr];
      end
   end

endmodule

// File: rtl/reg_bank_seq.sv
// Operand/write-back sequencer around a combinational 8-bit ALU. Accepts
// LDI and ALU instructions, stages operands to the ALU for one cycle, then
// writes the result (or immediate) back and latches the ALU flags.
module reg_bank_seq
   import reg_bank_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   reg_bank_seq_if.slave bus
);

   state_t state;
   state_t state_nxt;
   instr_t instr_q;
   logic   accept;
   logic   wr_en;
   logic   flags_en;
   addr_t  wr_addr;
   data_t  wr_data;
   data_t  rdata_x;
   data_t  rdata_y;
   data_t  rx_q;
   data_t  ry_q;
   op_t    sel_op_q;
   flags_t flags_q;

   assign bus.instr_ready_o = (state == IDLE);
   assign bus.done_o        = (state == DONE);
   assign accept            = bus.instr_valid_i & bus.instr_ready_o;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and write-strobe decode
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_nxt = state;
      wr_en     = 1'b0;
      flags_en  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = is_ldi(bus.instr_i) ? EX : RD;
            end
         end
         RD: begin
            state_nxt = EX;
         end
         EX: begin
            wr_en     = 1'b1;
            flags_en  = ~is_ldi(instr_q);
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Instruction latch, loaded only on a handshake in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
      end else if (accept) begin
         instr_q <= bus.instr_i;
      end
   end

   // ALU operand registers: change only at the end of RD, hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q     <= '0;
         ry_q     <= '0;
         sel_op_q <= '0;
      end else if (state == RD) begin
         rx_q     <= rdata_x;
         ry_q     <= rdata_y;
         sel_op_q <= instr_q[OP_MSB:OP_LSB];
      end
   end

   // Flag register: captures ALU Ban when an ALU instruction retires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (flags_en) begin
         flags_q <= bus.alu_ban_i;
      end
   end

   assign wr_addr = dst_of(instr_q);
   assign wr_data = is_ldi(instr_q) ? instr_q[IMM_MSB:IMM_LSB] : bus.alu_r0_i;

   assign bus.alu_rx_o     = rx_q;
   assign bus.alu_ry_o     = ry_q;
   assign bus.alu_sel_op_o = sel_op_q;
   assign bus.flags_o      = flags_q;

   reg_bank_rf u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_en),
      .waddr    (wr_addr),
      .wdata    (wr_data),
      .raddr_x  (instr_q[SRCX_MSB:SRCX_LSB]),
      .rdata_x  (rdata_x),
      .raddr_y  (instr_q[SRCY_MSB:SRCY_LSB]),
      .rdata_y  (rdata_y),
      .dbg_addr (bus.rd_addr_i),
      .dbg_data (bus.rd_data_o)
   );

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed bench for reg_bank_seq with a stub ALU: op0 add, op1 subtract,
// Ban = {Rx==Ry, carry/borrow, R0==0}. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_reg_bank_seq;
   import reg_bank_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   reg_bank_seq_if bus ();

   reg_bank_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Stub ALU
   logic [8:0] alu_ext;
   always_comb begin
      alu_ext = '0;
      case (bus.alu_sel_op_o)
         3'd0:    alu_ext = {1'b0, bus.alu_rx_o} + {1'b0, bus.alu_ry_o};
         3'd1:    alu_ext = {1'b0, bus.alu_rx_o} - {1'b0, bus.alu_ry_o};
         default: alu_ext = {1'b0, bus.alu_rx_o & bus.alu_ry_o};
      endcase
      bus.alu_r0_i  = alu_ext[7:0];
      bus.alu_ban_i = {bus.alu_rx_o == bus.alu_ry_o, alu_ext[8], alu_ext[7:0] == 8'h00};
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.instr_ready_o !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      check(tag, {15'd0, bus.instr_ready_o}, 16'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      bus.instr_i       = '0;
      bus.instr_valid_i = 1'b0;
      bus.rd_addr_i     = '0;
      tick();
      tick();

      // Reset values while reset is held
      check("rst_ready", {15'd0, bus.instr_ready_o}, 16'd1);
      check("rst_done",  {15'd0, bus.done_o},        16'd0);
      check("rst_flags", {13'd0, bus.flags_o},       16'd0);
      check("rst_rx",    {8'd0,  bus.alu_rx_o},      16'd0);
      check("rst_ry",    {8'd0,  bus.alu_ry_o},      16'd0);
      check("rst_sel",   {13'd0, bus.alu_sel_op_o},  16'd0);
      check("rst_rd",    {8'd0,  bus.rd_data_o},     16'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", {15'd0, bus.instr_ready_o}, 16'd1);

      // LDI r1=76, then LDI r2=44 presented during DONE
      bus.instr_i = 16'h904C; bus.instr_valid_i = 1'b1;
      tick();
      bus.instr_valid_i = 1'b0;
      check("ldi1_ex_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      check("ldi1_ex_done",  {15'd0, bus.done_o},        16'd0);
      tick();
      check("ldi1_done",       {15'd0, bus.done_o},        16'd1);
      check("ldi1_done_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      bus.instr_i = 16'hA02C; bus.instr_valid_i = 1'b1;
      tick();
      check("ldi1_idle_done",  {15'd0, bus.done_o},        16'd0);
      check("ldi1_idle_ready", {15'd0, bus.instr_ready_o}, 16'd1);
      tick();
      bus.instr_valid_i = 1'b0;
      check("ldi2_ex_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      tick();
      check("ldi2_done_3cyc", {15'd0, bus.done_o}, 16'd1);
      tick();
      bus.rd_addr_i = 3'd1;
      tick();
      check("ldi_r1", {8'd0, bus.rd_data_o}, 16'd76);
      bus.rd_addr_i = 3'd2;
      tick();
      check("ldi_r2",    {8'd0,  bus.rd_data_o}, 16'd44);
      check("ldi_flags", {13'd0, bus.flags_o},   16'd0);

      // ALU add: r3 = r1 + r2
      wait_ready("add_wait");
      bus.instr_i = 16'h0650; bus.instr_valid_i = 1'b1; bus.rd_addr_i = 3'd3;
      tick();
      bus.instr_valid_i = 1'b0;
      check("add_rd_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      check("add_rd_rx_hold", {8'd0, bus.alu_rx_o}, 16'd0);
      tick();
      check("add_ex_rx",    {8'd0,  bus.alu_rx_o},      16'd76);
      check("add_ex_ry",    {8'd0,  bus.alu_ry_o},      16'd44);
      check("add_ex_sel",   {13'd0, bus.alu_sel_op_o},  16'd0);
      check("add_ex_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      tick();
      check("add_done",     {15'd0, bus.done_o},  16'd1);
      check("add_flags",    {13'd0, bus.flags_o}, 16'd0);
      check("add_rd_old",   {8'd0,  bus.rd_data_o}, 16'd0);
      tick();
      check("add_r3", {8'd0, bus.rd_data_o}, 16'd120);

      // Self-operand: LDI r2=76, then r1 = r1 - r2
      wait_ready("self_wait");
      bus.instr_i = 16'hA04C; bus.instr_valid_i = 1'b1;
      tick();
      bus.instr_valid_i = 1'b0;
      tick();
      tick();
      bus.instr_i = 16'h1250; bus.instr_valid_i = 1'b1;
      tick();
      bus.instr_valid_i = 1'b0;
      tick();
      check("self_rx",  {8'd0,  bus.alu_rx_o},     16'd76);
      check("self_ry",  {8'd0,  bus.alu_ry_o},     16'd76);
      check("self_sel", {13'd0, bus.alu_sel_op_o}, 16'd1);
      tick();
      check("self_flags", {13'd0, bus.flags_o}, 16'b101);
      tick();
      bus.rd_addr_i = 3'd1;
      tick();
      check("self_r1", {8'd0, bus.rd_data_o}, 16'd0);

      // Handshake: valid held high over ALU r4=r3+r2 then LDI r6=0x22
      wait_ready("hs_wait");
      bus.instr_i = 16'h08D0; bus.instr_valid_i = 1'b1;
      tick();
      check("hs_rd_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      bus.instr_i = 16'hE022;
      tick();
      check("hs_ex_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      tick();
      check("hs_done_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      check("hs_done",       {15'd0, bus.done_o},        16'd1);
      tick();
      check("hs_idle_ready", {15'd0, bus.instr_ready_o}, 16'd1);
      check("hs_idle_done",  {15'd0, bus.done_o},        16'd0);
      check("hs_flags",      {13'd0, bus.flags_o},       16'd0);
      tick();
      bus.instr_valid_i = 1'b0;
      check("hs2_ex_ready", {15'd0, bus.instr_ready_o}, 16'd0);
      check("hs2_ex_done",  {15'd0, bus.done_o},        16'd0);
      tick();
      check("hs2_done", {15'd0, bus.done_o}, 16'd1);
      tick();
      check("hs2_idle_ready", {15'd0, bus.instr_ready_o}, 16'd1);
      check("hs_hold_rx",  {8'd0,  bus.alu_rx_o},     16'd120);
      check("hs_hold_ry",  {8'd0,  bus.alu_ry_o},     16'd76);
      check("hs_hold_sel", {13'd0, bus.alu_sel_op_o}, 16'd0);
      tick();
      check("hs_nodup_1", {15'd0, bus.done_o}, 16'd0);
      tick();
      check("hs_nodup_2", {15'd0, bus.done_o}, 16'd0);
      bus.rd_addr_i = 3'd4;
      tick();
      check("hs_r4", {8'd0, bus.rd_data_o}, 16'hC4);
      bus.rd_addr_i = 3'd6;
      tick();
      check("hs_r6", {8'd0, bus.rd_data_o}, 16'h22);

      // Reset during EX of r3 = r4 - r6
      wait_ready("mid_wait");
      bus.instr_i = 16'h1730; bus.instr_valid_i = 1'b1;
      tick();
      bus.instr_valid_i = 1'b0;
      tick();
      check("mid_ex_sel", {13'd0, bus.alu_sel_op_o}, 16'd1);
      check("mid_ex_rx",  {8'd0,  bus.alu_rx_o},     16'hC4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {15'd0, bus.instr_ready_o}, 16'd1);
      check("mid_rst_done",  {15'd0, bus.done_o},        16'd0);
      check("mid_rst_flags", {13'd0, bus.flags_o},       16'd0);
      check("mid_rst_rx",    {8'd0,  bus.alu_rx_o},      16'd0);
      check("mid_rst_ry",    {8'd0,  bus.alu_ry_o},      16'd0);
      check("mid_rst_sel",   {13'd0, bus.alu_sel_op_o},  16'd0);
      check("mid_rst_rd",    {8'd0,  bus.rd_data_o},     16'd0);
      tick();
      check("mid_rst_hold_done", {15'd0, bus.done_o}, 16'd0);
      rst_n = 1'b1;
      tick();
      check("mid_rel_ready", {15'd0, bus.instr_ready_o}, 16'd1);
      bus.rd_addr_i = 3'd3;
      tick();
      check("mid_r3", {8'd0, bus.rd_data_o}, 16'd0);
      check("mid_idle_done", {15'd0, bus.done_o}, 16'd0);

      // Debug read-during-write: LDI r5=0xAA while reading r5
      wait_ready("rdw_wait");
      bus.rd_addr_i = 3'd5;
      bus.instr_i = 16'hD0AA; bus.instr_valid_i = 1'b1;
      tick();
      bus.instr_valid_i = 1'b0;
      check("rdw_before", {8'd0, bus.rd_data_o}, 16'h00);
      tick();
      check("rdw_same", {8'd0, bus.rd_data_o}, 16'h00);
      tick();
      check("rdw_next", {8'd0, bus.rd_data_o}, 16'hAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
